rx_frame_analyser: RTL

Parametrised successor to the receive-side byte analyser. Assembles each UART frame from the per-bit samples delivered by the receive FSM. Supports a runtime data length, five parity modes, one or two stop bits and a selectable bit order. Writes good frames to the receive FIFO with a single-cycle active-low strobe, flags parity/framing/overrun errors per frame, and keeps saturating error counters. Sits in RxCore between the bit-sampling FSM/shift path and the RX FIFO.

---
 rtl/rx_pkg.sv | 52 +++++
 rtl/err_sat_counter.sv | 32 +++
 rtl/rx_frame_analyser.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/rx_pkg.sv
// ----------------------------------------------------------------------------
// rx_pkg
// Definitions shared by the receive-side frame analyser and its testbench:
//   - one-hot encodings of the receive FSM states
//   - parity mode codes
//   - bit order (BIGEND/LITTLEEND) and check result (WRONG/RIGHT) constants
//   - data-length bounds and parity helper functions
// ----------------------------------------------------------------------------
package rx_pkg;

    typedef enum logic [4:0] {
        ST_IDLE      = 5'b00001,
        ST_STARTBIT  = 5'b00010,
        ST_DATABITS  = 5'b00100,
        ST_PARITYBIT = 5'b01000,
        ST_STOPBIT   = 5'b10000
    } rx_state_e;

    // Codes 5..7 are not listed and behave like PAR_NONE.
    typedef enum logic [2:0] {
        PAR_NONE  = 3'd0,
        PAR_EVEN  = 3'd1,
        PAR_ODD   = 3'd2,
        PAR_MARK  = 3'd3,
        PAR_SPACE = 3'd4
    } parity_mode_e;

    localparam logic BIGEND    = 1'b1;
    localparam logic LITTLEEND = 1'b0;

    localparam logic WRONG = 1'b1;
    localparam logic RIGHT = 1'b0;

    localparam logic [3:0] MIN_DATA_LEN = 4'd5;

    // True for the modes that actually carry a parity bit worth checking.
    function automatic logic parity_checked(input logic [2:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD) ||
               (mode == PAR_MARK) || (mode == PAR_SPACE);
    endfunction

    // Parity bit the transmitter should have sent, given the XOR of the data.
    function automatic logic expected_parity(input logic [2:0] mode, input logic acc);
        case (mode)
            PAR_EVEN: return acc;
            PAR_ODD:  return ~acc;
            PAR_MARK: return 1'b1;
            default:  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/err_sat_counter.sv
// ----------------------------------------------------------------------------
// err_sat_counter
// Saturating event counter used for the per-error-type statistics.
//   clk    : system clock
//   rst    : asynchronous reset, active low
//   inc    : count one event this cycle
//   clr    : synchronous clear; a simultaneous inc leaves the count at 1
//   count  : current count, sticks at all-ones
// ----------------------------------------------------------------------------
module err_sat_counter #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count
);

    // A clear must not swallow the event that arrives with it, so clr+inc
    // restarts the count at one rather than zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? CNT_WIDTH'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/rx_frame_analyser.sv
// ----------------------------------------------------------------------------
// rx_frame_analyser
// Assembles UART frames from the per-bit samples of the receive FSM, checks
// parity and stop bits, writes good frames to the RX FIFO and keeps
// saturating error statistics.
//   clk, rst          : clock, asynchronous active-low reset
//   State_i           : one-hot receive FSM state (rx_pkg::rx_state_e)
//   bit_stb_i, bit_i  : bit acquisition strobe and sampled line value
//   data_len_i        : data bits per frame, clamped to 5..DATA_WIDTH
//   parity_mode_i     : none/even/odd/mark/space (rx_pkg::parity_mode_e)
//   p_TwoStop_i       : check two stop bits
//   p_BigEnd_i        : first data bit received is the MSB
//   p_DropBad_i       : do not write frames with parity/framing errors
//   clr_i             : clear the error counters
//   p_full_i          : RX FIFO full
//   n_we_o, data_o    : active-low FIFO write strobe and frame data
//   p_ParityError_o, p_FrameError_o, p_Overrun_o : flags of the latest frame
//   parity_err_cnt_o, frame_err_cnt_o, overrun_cnt_o : saturating counts
// ----------------------------------------------------------------------------
module rx_frame_analyser
    import rx_pkg::*;
#(
    parameter int DATA_WIDTH = 9,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            State_i,
    input  logic                  bit_stb_i,
    input  logic                  bit_i,
    input  logic [3:0]            data_len_i,
    input  logic [2:0]            parity_mode_i,
    input  logic                  p_TwoStop_i,
    input  logic                  p_BigEnd_i,
    input  logic                  p_DropBad_i,
    input  logic                  clr_i,
    output logic                  n_we_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic                  p_full_i,
    output logic                  p_ParityError_o,
    output logic                  p_FrameError_o,
    output logic                  p_Overrun_o,
    output logic [CNT_WIDTH-1:0]  parity_err_cnt_o,
    output logic [CNT_WIDTH-1:0]  frame_err_cnt_o,
    output logic [CNT_WIDTH-1:0]  overrun_cnt_o
);

    localparam logic [3:0] MAX_DATA_LEN = 4'(DATA_WIDTH);

    logic [3:0]            eff_len;
    logic [3:0]            bit_idx;
    logic [3:0]            bit_pos;
    logic [DATA_WIDTH-1:0] asm_reg;
    logic [DATA_WIDTH-1:0] asm_next;
    logic                  par_acc;
    logic                  stop_idx;
    logic                  commit_done;

    logic data_stb;
    logic parity_stb;
    logic parity_wrong;
    logic stop_stb;
    logic commit_now;
    logic frame_err_now;
    logic drop_frame;
    logic do_write;
    logic do_overrun;

    // Clamp the runtime data length into the supported window.
    always_comb begin
        eff_len = data_len_i;
        if (data_len_i < MIN_DATA_LEN) begin
            eff_len = MIN_DATA_LEN;
        end else if (data_len_i > MAX_DATA_LEN) begin
            eff_len = MAX_DATA_LEN;
        end
    end

    // Place the incoming data bit; big-end frames fill from the top of the
    // active field downwards so the result is always right-aligned.
    always_comb begin
        bit_pos  = (p_BigEnd_i == LITTLEEND) ? bit_idx : (eff_len - 4'd1 - bit_idx);
        asm_next = asm_reg;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            if (bit_pos == 4'(i)) begin
                asm_next[i] = bit_i;
            end
        end
    end

    // Strobe qualification and the commit decision. The decision is taken in
    // the cycle of the final stop strobe, so the framing result of that very
    // strobe has to be folded in combinationally.
    always_comb begin
        data_stb      = (State_i == ST_DATABITS) && bit_stb_i && (bit_idx < eff_len);
        parity_stb    = (State_i == ST_PARITYBIT) && bit_stb_i && parity_checked(parity_mode_i);
        parity_wrong  = (bit_i == expected_parity(parity_mode_i, par_acc)) ? RIGHT : WRONG;
        stop_stb      = (State_i == ST_STOPBIT) && bit_stb_i && !commit_done;
        commit_now    = stop_stb && (!p_TwoStop_i || stop_idx);
        frame_err_now = p_FrameError_o || !bit_i;
        drop_frame    = p_DropBad_i && (p_ParityError_o || frame_err_now);
        do_write      = commit_now && !drop_frame && !p_full_i;
        do_overrun    = commit_now && !drop_frame && p_full_i;
    end

    // Frame assembly and per-frame flags. STARTBIT wipes the frame context;
    // the write strobe is registered outside that branch so a STARTBIT right
    // after the final stop strobe cannot cancel the pending write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            n_we_o          <= 1'b1;
            data_o          <= '0;
            asm_reg         <= '0;
            bit_idx         <= '0;
            par_acc         <= 1'b0;
            stop_idx        <= 1'b0;
            commit_done     <= 1'b0;
            p_ParityError_o <= 1'b0;
            p_FrameError_o  <= 1'b0;
            p_Overrun_o     <= 1'b0;
        end else begin
            n_we_o <= !do_write;
            if (do_write) begin
                data_o <= asm_reg;
            end

            if (State_i == ST_STARTBIT) begin
                asm_reg         <= '0;
                bit_idx         <= '0;
                par_acc         <= 1'b0;
                stop_idx        <= 1'b0;
                commit_done     <= 1'b0;
                p_ParityError_o <= 1'b0;
                p_FrameError_o  <= 1'b0;
                p_Overrun_o     <= 1'b0;
            end else begin
                if (data_stb) begin
                    asm_reg <= asm_next;
                    par_acc <= par_acc ^ bit_i;
                    bit_idx <= bit_idx + 4'd1;
                end
                if (parity_stb && (parity_wrong == WRONG)) begin
                    p_ParityError_o <= 1'b1;
                end
                if (stop_stb) begin
                    stop_idx <= 1'b1;
                    if (!bit_i) begin
                        p_FrameError_o <= 1'b1;
                    end
                    if (commit_now) begin
                        commit_done <= 1'b1;
                        if (do_overrun) begin
                            p_Overrun_o <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    // Error statistics are counted on commit, whether or not the frame is
    // written, so aborted frames never touch them.
    err_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_parity_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (commit_now && p_ParityError_o),
        .clr   (clr_i),
        .count (parity_err_cnt_o)
    );

    err_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_frame_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (commit_now && frame_err_now),
        .clr   (clr_i),
        .count (frame_err_cnt_o)
    );

    err_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_overrun_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (do_overrun),
        .clr   (clr_i),
        .count (overrun_cnt_o)
    );

endmodule
